rename_map_table: RTL and testbench

Speculative register-alias table for the out-of-order RISC-V core's rename stage; it is the direct consumer of `free_list`. Each dispatched instruction with a destination pops one physical tag from the free list, remaps its architectural destination to that tag, and reports the displaced tag to the ROB. Source registers are translated to physical tags with a ready bit maintained from CDB broadcasts. On branch recovery the whole table is reloaded from the retirement map.

---
 rtl/rename_map_table_pkg.sv | 28 ++
 rtl/rename_map_table_if.sv | 37 +++
 rtl/rename_map_table_entry.sv | 43 ++++
 rtl/rename_map_table.sv | 64 ++++++
 tb/tb_rename_map_table.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/rename_map_table_pkg.sv
// Shared types for the rename map table: arch/physical index widths and the map entry layout.
// The physical tag width follows the CDB_BITS macro shared with free_list.
`ifndef CDB_BITS
`define CDB_BITS 7
`endif

package rename_pkg;

  localparam int unsigned NUM_ARCH_REGS = 32;
  localparam int unsigned ARCH_BITS     = 5;

  typedef logic [`CDB_BITS-1:0] preg_t;
  typedef logic [ARCH_BITS-1:0] areg_t;

  typedef struct packed {
    preg_t tag;
    logic  ready;
  } map_entry_t;

  // Reset image of entry idx: arch reg i maps to physical tag i, value available
  function automatic map_entry_t identityEntry(input int unsigned idx);
    map_entry_t e;
    e.tag   = preg_t'(idx);
    e.ready = 1'b1;
    return e;
  endfunction

endpackage

// File: rtl/rename_map_table_if.sv
// Rename-stage bundle: dispatch request, free-list pop, CDB broadcast, recovery load and lookup results.
interface rename_map_table_if;
  import rename_pkg::*;

  logic                      dispatch_valid;
  logic                      dispatch_has_dest;
  areg_t                     dispatch_rd;
  areg_t                     dispatch_rs1;
  areg_t                     dispatch_rs2;
  preg_t                     fl_data;
  logic                      fl_empty;
  logic                      fl_rd;
  logic                      dispatch_stall;
  preg_t                     rs1_tag;
  preg_t                     rs2_tag;
  logic                      rs1_ready;
  logic                      rs2_ready;
  preg_t                     new_tag;
  preg_t                     old_tag;
  logic                      cdb_valid;
  preg_t                     cdb_tag;
  logic                      recover;
  preg_t [NUM_ARCH_REGS-1:0] arch_map_in;

  modport master (
    output dispatch_valid, dispatch_has_dest, dispatch_rd, dispatch_rs1, dispatch_rs2,
    output fl_data, fl_empty, cdb_valid, cdb_tag, recover, arch_map_in,
    input  fl_rd, dispatch_stall, rs1_tag, rs2_tag, rs1_ready, rs2_ready, new_tag, old_tag
  );

  modport slave (
    input  dispatch_valid, dispatch_has_dest, dispatch_rd, dispatch_rs1, dispatch_rs2,
    input  fl_data, fl_empty, cdb_valid, cdb_tag, recover, arch_map_in,
    output fl_rd, dispatch_stall, rs1_tag, rs2_tag, rs1_ready, rs2_ready, new_tag, old_tag
  );

endinterface

// File: rtl/rename_map_table_entry.sv
// One speculative map entry {tag, ready}: recovery load beats dispatch write beats CDB wakeup.
module rename_map_entry
  import rename_pkg::*;
#(
  parameter int unsigned INDEX = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       we_i,
  input  preg_t      wtag_i,
  input  logic       load_i,
  input  preg_t      ltag_i,
  input  logic       cdb_valid_i,
  input  preg_t      cdb_tag_i,
  output map_entry_t entry_o
);

  map_entry_t entry_q, entry_d;

  always_comb begin
    entry_d = entry_q;
    if (load_i) begin
      entry_d.tag   = ltag_i;
      entry_d.ready = 1'b1;
    end else if (we_i) begin
      entry_d.tag   = wtag_i;
      entry_d.ready = 1'b0;
    end else if (cdb_valid_i && (entry_q.tag == cdb_tag_i)) begin
      entry_d.ready = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      entry_q <= identityEntry(INDEX);
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/rename_map_table.sv
// Speculative register-alias table: pops free-list tags for rd, translates rs1/rs2, reloads on recover.
// Optional RENAME_CDB_FWD_EN forwards a same-cycle CDB broadcast into rs1_ready/rs2_ready.
module rename_map_table
  import rename_pkg::*;
(
  input logic               clock,
  input logic               reset,
  rename_map_table_if.slave bus
);

  map_entry_t entries [NUM_ARCH_REGS];
  logic       alloc;
  map_entry_t rs1Entry, rs2Entry, rdEntry;

  // Holding reset keeps the free list untouched while the table sits at identity
  assign alloc = bus.dispatch_valid & bus.dispatch_has_dest & (bus.dispatch_rd != '0)
               & ~bus.recover & ~reset;

  for (genvar i = 0; i < NUM_ARCH_REGS; i++) begin : gEntry
    logic  weEntry;
    preg_t loadTag;

    assign weEntry = alloc & ~bus.fl_empty & (bus.dispatch_rd == areg_t'(i));

    // x0 reloads as tag 0 regardless of the retirement map, so it always reads {0, 1}
    if (i == 0) begin : gZero
      assign loadTag = '0;
    end else begin : gReg
      assign loadTag = bus.arch_map_in[i];
    end

    rename_map_entry #(.INDEX(i)) uEntry (
      .clock       (clock),
      .reset       (reset),
      .we_i        (weEntry),
      .wtag_i      (bus.fl_data),
      .load_i      (bus.recover),
      .ltag_i      (loadTag),
      .cdb_valid_i (bus.cdb_valid),
      .cdb_tag_i   (bus.cdb_tag),
      .entry_o     (entries[i])
    );
  end

  always_comb begin
    rs1Entry           = entries[bus.dispatch_rs1];
    rs2Entry           = entries[bus.dispatch_rs2];
    rdEntry            = entries[bus.dispatch_rd];
    bus.fl_rd          = alloc & ~bus.fl_empty;
    bus.dispatch_stall = alloc & bus.fl_empty;
    bus.rs1_tag        = rs1Entry.tag;
    bus.rs2_tag        = rs2Entry.tag;
    bus.new_tag        = bus.fl_data;
    bus.old_tag        = rdEntry.tag;
`ifdef RENAME_CDB_FWD_EN
    bus.rs1_ready      = rs1Entry.ready | (bus.cdb_valid & (bus.cdb_tag == rs1Entry.tag));
    bus.rs2_ready      = rs2Entry.ready | (bus.cdb_valid & (bus.cdb_tag == rs2Entry.tag));
`else
    bus.rs1_ready      = rs1Entry.ready;
    bus.rs2_ready      = rs2Entry.ready;
`endif
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Directed bench for rename_map_table: lookups, allocation, stall, CDB wakeup, recovery and async reset.
module tb_rename_map_table;
  import rename_pkg::*;

  logic clock;
  logic reset;
  int   passCount;
  int   checkCount;

  rename_map_table_if bus ();

  rename_map_table dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic hasDest, input int rd,
                               input int rs1, input int rs2, input int flData, input logic flEmpty);
    bus.dispatch_valid    = valid;
    bus.dispatch_has_dest = hasDest;
    bus.dispatch_rd       = areg_t'(rd);
    bus.dispatch_rs1      = areg_t'(rs1);
    bus.dispatch_rs2      = areg_t'(rs2);
    bus.fl_data           = preg_t'(flData);
    bus.fl_empty          = flEmpty;
    #2;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic setIdentityArchMap();
    for (int i = 0; i < NUM_ARCH_REGS; i++) bus.arch_map_in[i] = preg_t'(i);
  endtask

  initial begin
    passCount  = 0;
    checkCount = 0;
    reset      = 1'b1;
    bus.cdb_valid = 1'b0;
    bus.cdb_tag   = '0;
    bus.recover   = 1'b0;
    setIdentityArchMap();

    // Outputs while reset is held, even with a dispatch presented
    applyStimulus(1'b1, 1'b1, 6, 9, 12, 'h2f, 1'b0);
    checkOutput("rst_fl_rd", 32'(bus.fl_rd), 32'd0);
    checkOutput("rst_stall", 32'(bus.dispatch_stall), 32'd0);
    checkOutput("rst_rs1_tag", 32'(bus.rs1_tag), 32'h09);
    checkOutput("rst_rs2_tag", 32'(bus.rs2_tag), 32'h0c);
    checkOutput("rst_new_tag", 32'(bus.new_tag), 32'h2f);
    checkOutput("rst_old_tag", 32'(bus.old_tag), 32'h06);
    nextCycle();
    reset = 1'b0;

    // Plain lookup, including x0
    applyStimulus(1'b0, 1'b0, 0, 5, 0, 'h20, 1'b0);
    checkOutput("lk_rs1_tag", 32'(bus.rs1_tag), 32'h05);
    checkOutput("lk_rs1_rdy", 32'(bus.rs1_ready), 32'd1);
    checkOutput("lk_rs2_tag", 32'(bus.rs2_tag), 32'h00);
    checkOutput("lk_rs2_rdy", 32'(bus.rs2_ready), 32'd1);
    checkOutput("lk_fl_rd", 32'(bus.fl_rd), 32'd0);

    // Allocate rd=3 -> 0x20; rs1==rd still sees the old mapping this cycle
    applyStimulus(1'b1, 1'b1, 3, 3, 0, 'h20, 1'b0);
    checkOutput("al_fl_rd", 32'(bus.fl_rd), 32'd1);
    checkOutput("al_stall", 32'(bus.dispatch_stall), 32'd0);
    checkOutput("al_new_tag", 32'(bus.new_tag), 32'h20);
    checkOutput("al_old_tag", 32'(bus.old_tag), 32'h03);
    checkOutput("al_rs1_pre", 32'(bus.rs1_tag), 32'h03);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 0, 3, 0, 'h21, 1'b0);
    checkOutput("al_rs1_tag", 32'(bus.rs1_tag), 32'h20);
    checkOutput("al_rs1_rdy", 32'(bus.rs1_ready), 32'd0);

    // CDB wakeup of tag 0x20
    bus.cdb_valid = 1'b1;
    bus.cdb_tag   = preg_t'('h20);
    #1;
`ifdef RENAME_CDB_FWD_EN
    checkOutput("cdb_same", 32'(bus.rs1_ready), 32'd1);
`else
    checkOutput("cdb_same", 32'(bus.rs1_ready), 32'd0);
`endif
    checkOutput("cdb_other", 32'(bus.rs2_ready), 32'd1);
    nextCycle();
    bus.cdb_valid = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 3, 0, 'h21, 1'b0);
    checkOutput("cdb_next", 32'(bus.rs1_ready), 32'd1);
    checkOutput("cdb_tag_kept", 32'(bus.rs1_tag), 32'h20);

    // Stall on empty free list leaves map[4] alone
    applyStimulus(1'b1, 1'b1, 4, 4, 0, 'h21, 1'b1);
    checkOutput("st_stall", 32'(bus.dispatch_stall), 32'd1);
    checkOutput("st_fl_rd", 32'(bus.fl_rd), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 0, 4, 0, 'h21, 1'b1);
    checkOutput("st_map4_tag", 32'(bus.rs1_tag), 32'h04);
    checkOutput("st_map4_rdy", 32'(bus.rs1_ready), 32'd1);

    // rd = x0 and no-dest never allocate
    applyStimulus(1'b1, 1'b1, 0, 0, 0, 'h21, 1'b0);
    checkOutput("x0_fl_rd", 32'(bus.fl_rd), 32'd0);
    checkOutput("x0_stall", 32'(bus.dispatch_stall), 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 5, 0, 0, 'h21, 1'b1);
    checkOutput("nd_fl_rd", 32'(bus.fl_rd), 32'd0);
    checkOutput("nd_stall", 32'(bus.dispatch_stall), 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 0, 0, 5, 'h21, 1'b0);
    checkOutput("x0_map_tag", 32'(bus.rs1_tag), 32'h00);
    checkOutput("nd_map5_tag", 32'(bus.rs2_tag), 32'h05);

    // Back-to-back renames of x7 chain through old_tag
    applyStimulus(1'b1, 1'b1, 7, 0, 0, 'h21, 1'b0);
    checkOutput("ch1_old_tag", 32'(bus.old_tag), 32'h07);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 7, 0, 0, 'h22, 1'b0);
    checkOutput("ch2_old_tag", 32'(bus.old_tag), 32'h21);
    checkOutput("ch2_new_tag", 32'(bus.new_tag), 32'h22);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 0, 7, 0, 'h23, 1'b0);
    checkOutput("ch_rs1_tag", 32'(bus.rs1_tag), 32'h22);
    checkOutput("ch_rs1_rdy", 32'(bus.rs1_ready), 32'd0);

    // Recover with identity map; the dispatch in that cycle must not pop
    bus.recover = 1'b1;
    applyStimulus(1'b1, 1'b1, 9, 7, 3, 'h23, 1'b0);
    checkOutput("rc_fl_rd", 32'(bus.fl_rd), 32'd0);
    checkOutput("rc_stall", 32'(bus.dispatch_stall), 32'd0);
    nextCycle();
    bus.recover = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 7, 3, 'h23, 1'b0);
    checkOutput("rc_rs1_tag", 32'(bus.rs1_tag), 32'h07);
    checkOutput("rc_rs1_rdy", 32'(bus.rs1_ready), 32'd1);
    checkOutput("rc_rs2_tag", 32'(bus.rs2_tag), 32'h03);
    applyStimulus(1'b0, 1'b0, 0, 9, 0, 'h23, 1'b0);
    checkOutput("rc_map9_tag", 32'(bus.rs1_tag), 32'h09);

    // Recover from a non-identity retirement map; x0 ignores it
    bus.arch_map_in[5] = preg_t'('h30);
    bus.arch_map_in[0] = preg_t'('h33);
    bus.recover = 1'b1;
    nextCycle();
    bus.recover = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 5, 0, 'h23, 1'b0);
    checkOutput("rc2_map5_tag", 32'(bus.rs1_tag), 32'h30);
    checkOutput("rc2_map5_rdy", 32'(bus.rs1_ready), 32'd1);
    checkOutput("rc2_x0_tag", 32'(bus.rs2_tag), 32'h00);
    setIdentityArchMap();

    // Allocate rd=5, then assert reset mid-cycle with no clock edge in between
    applyStimulus(1'b1, 1'b1, 5, 0, 0, 'h24, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 6, 5, 0, 'h25, 1'b0);
    checkOutput("ar_pre_tag", 32'(bus.rs1_tag), 32'h24);
    reset = 1'b1;
    #1;
    checkOutput("ar_rs1_tag", 32'(bus.rs1_tag), 32'h05);
    checkOutput("ar_rs1_rdy", 32'(bus.rs1_ready), 32'd1);
    checkOutput("ar_fl_rd", 32'(bus.fl_rd), 32'd0);
    checkOutput("ar_old_tag", 32'(bus.old_tag), 32'h06);
    nextCycle();
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 0, 7, 3, 'h25, 1'b0);
    checkOutput("ar_map7_tag", 32'(bus.rs1_tag), 32'h07);
    checkOutput("ar_map3_tag", 32'(bus.rs2_tag), 32'h03);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
